// File: rtl/bch_hard_sched_if.sv
// Request, core and response bundle for bch_hard_sched; master = scheduler, slave = environment.
// rsp_timeout exists only when BCH_SCHED_TIMEOUT_EN is defined.
interface bch_hard_sched_if #(
  parameter int NREQ  = 4,
  parameter int N_MAX = 63,
  parameter int IDW   = $clog2(NREQ)
);
  logic [NREQ-1:0]       req;
  logic [NREQ*10-1:0]    req_n;
  logic [NREQ*4-1:0]     req_t;
  logic [NREQ*4-1:0]     req_m;
  logic [NREQ*N_MAX-1:0] req_bits;
  logic [NREQ-1:0]       gnt;

  logic                  core_start;
  logic [9:0]            core_n;
  logic [3:0]            core_t;
  logic [3:0]            core_m;
  logic [N_MAX-1:0]      core_bits;
  logic                  core_done;
  logic                  core_success;
  logic [N_MAX-1:0]      core_err_vec;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic                  rsp_success;
  logic [N_MAX-1:0]      rsp_err_vec;
  logic                  rsp_cfg_err;
`ifdef BCH_SCHED_TIMEOUT_EN
  logic                  rsp_timeout;
`endif
  logic                  busy;

  modport master (
    input  req, req_n, req_t, req_m, req_bits,
    output gnt,
    output core_start, core_n, core_t, core_m, core_bits,
    input  core_done, core_success, core_err_vec,
    output rsp_valid, rsp_id, rsp_success, rsp_err_vec, rsp_cfg_err,
    input  rsp_ready,
`ifdef BCH_SCHED_TIMEOUT_EN
    output rsp_timeout,
`endif
    output busy
  );

  modport slave (
    output req, req_n, req_t, req_m, req_bits,
    input  gnt,
    input  core_start, core_n, core_t, core_m, core_bits,
    output core_done, core_success, core_err_vec,
    input  rsp_valid, rsp_id, rsp_success, rsp_err_vec, rsp_cfg_err,
    output rsp_ready,
`ifdef BCH_SCHED_TIMEOUT_EN
    input  rsp_timeout,
`endif
    input  busy
  );
endinterface

// File: rtl/bch_hard_sched.sv
// Round-robin scheduler sharing one bch_hard_core among NREQ requesters, result returned on valid/ready.
// Optional WAIT watchdog enabled by defining BCH_SCHED_TIMEOUT_EN.
module bch_hard_sched #(
  parameter int NREQ    = 4,
  parameter int N_MAX   = 63,
  parameter int T_MAX   = 4,
  parameter int M_MAX   = 10,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  bch_hard_sched_if.master  bus
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [9:0]       n_q, n_d;
  logic [3:0]       t_q, t_d;
  logic [3:0]       m_q, m_d;
  logic [N_MAX-1:0] bits_q, bits_d;
  logic             start_q, start_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             success_q, success_d;
  logic [N_MAX-1:0] err_q, err_d;
  logic             cfg_err_q, cfg_err_d;
  logic             busy_q, busy_d;

`ifdef BCH_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`else
  logic             unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  logic             any_req;
  logic [IDW-1:0]   win;
  logic             found;
  logic [IDW:0]     idx;
  logic [NREQ-1:0]  gnt_vec;
  logic [9:0]       sel_n;
  logic [3:0]       sel_t;
  logic [3:0]       sel_m;
  logic [N_MAX-1:0] sel_bits;
  logic             cfg_bad;

  assign any_req = |bus.req;

  // First set request at or above the pointer, wrapping modulo NREQ.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr_q} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NREQ)) begin
        idx = idx - (IDW+1)'(NREQ);
      end
      if (!found && bus.req[idx[IDW-1:0]]) begin
        found = 1'b1;
        win   = idx[IDW-1:0];
      end
    end
  end

  assign sel_n    = bus.req_n[10*win +: 10];
  assign sel_t    = bus.req_t[4*win +: 4];
  assign sel_m    = bus.req_m[4*win +: 4];
  assign sel_bits = bus.req_bits[N_MAX*win +: N_MAX];

  assign cfg_bad = (sel_t == 4'd0) || (sel_t > 4'(T_MAX)) || (sel_m > 4'(M_MAX)) ||
                   (sel_n > 10'(N_MAX)) || (sel_n == 10'd0);

  // The grant is the capture strobe, so it must appear in the capturing IDLE cycle.
  assign gnt_vec = (state_q == IDLE && any_req && !rst) ?
                   ({{(NREQ-1){1'b0}}, 1'b1} << win) : '0;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    n_d         = n_q;
    t_d         = t_q;
    m_d         = m_q;
    bits_d      = bits_q;
    start_d     = 1'b0;
    rsp_valid_d = rsp_valid_q;
    success_d   = success_q;
    err_d       = err_q;
    cfg_err_d   = cfg_err_q;
`ifdef BCH_SCHED_TIMEOUT_EN
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) begin
          id_d   = win;
          n_d    = sel_n;
          t_d    = sel_t;
          m_d    = sel_m;
          bits_d = sel_bits;
          if (cfg_bad) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            success_d   = 1'b0;
            err_d       = '0;
            cfg_err_d   = 1'b1;
`ifdef BCH_SCHED_TIMEOUT_EN
            timeout_d   = 1'b0;
`endif
          end else begin
            state_d = LAUNCH;
            start_d = 1'b1;
          end
        end
      end
      LAUNCH: begin
        state_d = WAIT;
`ifdef BCH_SCHED_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        if (bus.core_done) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          success_d   = bus.core_success;
          err_d       = bus.core_success ? bus.core_err_vec : '0;
          cfg_err_d   = 1'b0;
`ifdef BCH_SCHED_TIMEOUT_EN
          timeout_d   = 1'b0;
`endif
        end
`ifdef BCH_SCHED_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          success_d   = 1'b0;
          err_d       = '0;
          cfg_err_d   = 1'b0;
          timeout_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          ptr_d       = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      n_q         <= '0;
      t_q         <= '0;
      m_q         <= '0;
      bits_q      <= '0;
      start_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      success_q   <= 1'b0;
      err_q       <= '0;
      cfg_err_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef BCH_SCHED_TIMEOUT_EN
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      n_q         <= n_d;
      t_q         <= t_d;
      m_q         <= m_d;
      bits_q      <= bits_d;
      start_q     <= start_d;
      rsp_valid_q <= rsp_valid_d;
      success_q   <= success_d;
      err_q       <= err_d;
      cfg_err_q   <= cfg_err_d;
      busy_q      <= busy_d;
`ifdef BCH_SCHED_TIMEOUT_EN
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign bus.gnt         = gnt_vec;
  assign bus.core_start  = start_q;
  assign bus.core_n      = n_q;
  assign bus.core_t      = t_q;
  assign bus.core_m      = m_q;
  assign bus.core_bits   = bits_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = id_q;
  assign bus.rsp_success = success_q;
  assign bus.rsp_err_vec = err_q;
  assign bus.rsp_cfg_err = cfg_err_q;
  assign bus.busy        = busy_q;
`ifdef BCH_SCHED_TIMEOUT_EN
  assign bus.rsp_timeout = timeout_q;
`endif

endmodule

// File: tb/tb_bch_hard_sched.sv
// Directed + randomized bench for bch_hard_sched with a queue-free round-robin reference model and a core model.
module tb_bch_hard_sched;
  localparam int NREQ    = 4;
  localparam int N_MAX   = 63;
  localparam int TIMEOUT = 1023;

  logic clk;
  logic rst;

  bch_hard_sched_if #(.NREQ(NREQ), .N_MAX(N_MAX)) bus ();

  bch_hard_sched #(.NREQ(NREQ), .N_MAX(N_MAX), .T_MAX(4), .M_MAX(10), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [9:0]  cfg_n    [NREQ];
  logic [3:0]  cfg_t    [NREQ];
  logic [3:0]  cfg_m    [NREQ];
  logic [62:0] cfg_bits [NREQ];

  int          core_delay = 5;
  bit          core_succ  = 1'b1;
  logic [62:0] core_err   = '0;
  bit          core_hang  = 1'b0;
  int          start_count = 0;
  int          m_ptr = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Core model: done pulse core_delay cycles after the start pulse is seen.
  initial begin
    int cnt;
    cnt = 0;
    bus.core_done    = 1'b0;
    bus.core_success = 1'b0;
    bus.core_err_vec = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cnt = 0;
        bus.core_done = 1'b0;
      end else begin
        bus.core_done = 1'b0;
        if (bus.core_start === 1'b1) begin
          start_count++;
          cnt = core_delay;
        end else if (cnt > 0) begin
          cnt--;
          if (cnt == 0 && !core_hang) begin
            bus.core_done    = 1'b1;
            bus.core_success = core_succ;
            bus.core_err_vec = core_err;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit cfg_ok(input logic [9:0] n, input logic [3:0] t, input logic [3:0] m);
    return (n >= 1) && (n <= 63) && (t >= 1) && (t <= 4) && (m <= 10);
  endfunction

  function automatic int rr_pick(input logic [3:0] mask, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [62:0] rand_bits();
    return {$urandom, $urandom};
  endfunction

  task automatic rand_cfg(input int ch, input bit legal);
    cfg_bits[ch] = rand_bits();
    cfg_n[ch] = 10'($urandom_range(1, 63));
    cfg_t[ch] = 4'($urandom_range(1, 4));
    cfg_m[ch] = 4'($urandom_range(0, 10));
    if (!legal) begin
      case ($urandom_range(0, 4))
        0: cfg_t[ch] = 4'd0;
        1: cfg_t[ch] = 4'($urandom_range(5, 15));
        2: cfg_m[ch] = 4'($urandom_range(11, 15));
        3: cfg_n[ch] = 10'd0;
        default: cfg_n[ch] = 10'($urandom_range(64, 1023));
      endcase
    end
  endtask

  task automatic set_req(input logic [3:0] mask);
    for (int ch = 0; ch < NREQ; ch++) begin
      bus.req_n[10*ch +: 10]       = cfg_n[ch];
      bus.req_t[4*ch +: 4]         = cfg_t[ch];
      bus.req_m[4*ch +: 4]         = cfg_m[ch];
      bus.req_bits[N_MAX*ch +: N_MAX] = cfg_bits[ch];
    end
    bus.req = mask;
  endtask

  // One full request/response exchange, called and returning at a negedge with the DUT idle.
  task automatic txn(input logic [3:0] mask, input int stall);
    int w, s0, cyc;
    bit ok, exp_succ, gnt_seen;
    logic [62:0] exp_err;
    logic [3:0] exp_gnt;
    w  = rr_pick(mask, m_ptr);
    ok = cfg_ok(cfg_n[w], cfg_t[w], cfg_m[w]);
    s0 = start_count;
    exp_gnt = 4'b0001 << w;
    set_req(mask);
    #1;
    chk("gnt", 64'(bus.gnt), 64'(exp_gnt));
    @(negedge clk);
    bus.req[w] = 1'b0;
    if (ok) begin
      chk("core_start", 64'(bus.core_start), 64'd1);
      chk("core_n", 64'(bus.core_n), 64'(cfg_n[w]));
      chk("core_t", 64'(bus.core_t), 64'(cfg_t[w]));
      chk("core_m", 64'(bus.core_m), 64'(cfg_m[w]));
      chk("core_bits", 64'(bus.core_bits), 64'(cfg_bits[w]));
      exp_succ = core_succ;
      exp_err  = core_succ ? core_err : 63'd0;
    end else begin
      chk("cfg_err_start", 64'(bus.core_start), 64'd0);
      chk("cfg_err_valid", 64'(bus.rsp_valid), 64'd1);
      exp_succ = 1'b0;
      exp_err  = '0;
    end
    cyc = 0;
    while (bus.rsp_valid !== 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("rsp_wait_bound", 64'(cyc < 2000), 64'd1);
    if (ok) chk("latency", 64'(cyc), 64'(core_delay + 1));
    chk("rsp_id", 64'(bus.rsp_id), 64'(w));
    chk("rsp_success", 64'(bus.rsp_success), 64'(exp_succ));
    chk("rsp_err_vec", 64'(bus.rsp_err_vec), 64'(exp_err));
    chk("rsp_cfg_err", 64'(bus.rsp_cfg_err), 64'(!ok));
    chk("busy", 64'(bus.busy), 64'd1);
`ifdef BCH_SCHED_TIMEOUT_EN
    chk("rsp_timeout", 64'(bus.rsp_timeout), 64'd0);
`endif
    gnt_seen = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      gnt_seen = gnt_seen | (|bus.gnt);
    end
    if (stall > 0) begin
      chk("stall_valid", 64'(bus.rsp_valid), 64'd1);
      chk("stall_id", 64'(bus.rsp_id), 64'(w));
      chk("stall_err_vec", 64'(bus.rsp_err_vec), 64'(exp_err));
      chk("stall_success", 64'(bus.rsp_success), 64'(exp_succ));
      chk("stall_no_gnt", 64'(gnt_seen), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req = '0;
    chk("rsp_dropped", 64'(bus.rsp_valid), 64'd0);
    chk("start_count", 64'(start_count), 64'(s0 + (ok ? 1 : 0)));
    m_ptr = (w + 1) % NREQ;
  endtask

  initial begin
    rst = 1'b1;
    bus.req = '0;
    bus.req_n = '0;
    bus.req_t = '0;
    bus.req_m = '0;
    bus.req_bits = '0;
    bus.rsp_ready = 1'b0;
    for (int ch = 0; ch < NREQ; ch++) rand_cfg(ch, 1'b1);
    repeat (3) @(negedge clk);
    chk("rst_gnt", 64'(bus.gnt), 64'd0);
    chk("rst_core_start", 64'(bus.core_start), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_core_n", 64'(bus.core_n), 64'd0);
    chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    m_ptr = 0;

    // Round robin from pointer 0 with all four requesting: expect 0,1,2,3,0.
    for (int r = 0; r < 5; r++) begin
      for (int ch = 0; ch < NREQ; ch++) rand_cfg(ch, 1'b1);
      core_delay = $urandom_range(1, 4);
      core_succ  = 1'b1;
      core_err   = rand_bits();
      chk("rr_order", 64'(rr_pick(4'b1111, m_ptr)), 64'(r % NREQ));
      txn(4'b1111, 0);
    end

    // Single request on channel 0.
    cfg_n[0] = 10'd63; cfg_t[0] = 4'd2; cfg_m[0] = 4'd6; cfg_bits[0] = rand_bits();
    core_delay = 5; core_succ = 1'b1; core_err = 63'h3;
    txn(4'b0001, 0);

    // Backpressure for 10 cycles while others request.
    for (int ch = 0; ch < NREQ; ch++) rand_cfg(ch, 1'b1);
    core_delay = 3; core_err = rand_bits();
    txn(4'b1111, 10);

    // Illegal t on channel 2.
    rand_cfg(2, 1'b1);
    cfg_t[2] = 4'd5;
    txn(4'b0100, 2);

    // Legal boundary configs.
    cfg_n[3] = 10'd63; cfg_t[3] = 4'd4; cfg_m[3] = 4'd10;
    core_delay = 1; core_err = rand_bits();
    txn(4'b1000, 0);
    cfg_n[1] = 10'd1; cfg_t[1] = 4'd1; cfg_m[1] = 4'd0;
    txn(4'b0010, 0);
    // Illegal boundary configs.
    cfg_n[0] = 10'd64; cfg_t[0] = 4'd4; cfg_m[0] = 4'd10;
    txn(4'b0001, 0);
    rand_cfg(1, 1'b1); cfg_m[1] = 4'd11;
    txn(4'b0010, 0);
    rand_cfg(2, 1'b1); cfg_t[2] = 4'd0;
    txn(4'b0100, 0);
    rand_cfg(3, 1'b1); cfg_n[3] = 10'd0;
    txn(4'b1000, 0);

    // Core failure: error vector must be suppressed.
    rand_cfg(3, 1'b1);
    core_succ = 1'b0; core_err = 63'hFF; core_delay = 4;
    txn(4'b1000, 0);

    // Randomized traffic.
    for (int r = 0; r < 40; r++) begin
      logic [3:0] mask;
      mask = 4'($urandom_range(1, 15));
      for (int ch = 0; ch < NREQ; ch++) rand_cfg(ch, $urandom_range(0, 4) != 0);
      core_delay = $urandom_range(1, 8);
      core_succ  = $urandom_range(0, 1);
      core_err   = rand_bits();
      txn(mask, $urandom_range(0, 3));
    end

    // Leave the pointer at 1, then abort a decode in WAIT with reset.
    rand_cfg(0, 1'b1); core_succ = 1'b1; core_delay = 2;
    txn(4'b0001, 0);
    rand_cfg(2, 1'b1); core_delay = 50;
    set_req(4'b0100);
    @(negedge clk);
    bus.req = '0;
    chk("abort_start", 64'(bus.core_start), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_core_start", 64'(bus.core_start), 64'd0);
    chk("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("abort_gnt", 64'(bus.gnt), 64'd0);
    chk("abort_core_n", 64'(bus.core_n), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    @(negedge clk);
    for (int ch = 0; ch < NREQ; ch++) rand_cfg(ch, 1'b1);
    core_delay = 2;
    txn(4'b1001, 0);

`ifdef BCH_SCHED_TIMEOUT_EN
    begin
      int w, cyc;
      for (int ch = 0; ch < NREQ; ch++) rand_cfg(ch, 1'b1);
      core_hang = 1'b1;
      core_delay = 1;
      w = rr_pick(4'b0010, m_ptr);
      set_req(4'b0010);
      @(negedge clk);
      bus.req = '0;
      chk("to_start", 64'(bus.core_start), 64'd1);
      cyc = 0;
      while (bus.rsp_valid !== 1'b1 && cyc < 2000) begin
        @(negedge clk);
        cyc++;
      end
      chk("to_latency", 64'(cyc), 64'(TIMEOUT + 1));
      chk("to_flag", 64'(bus.rsp_timeout), 64'd1);
      chk("to_id", 64'(bus.rsp_id), 64'(w));
      chk("to_success", 64'(bus.rsp_success), 64'd0);
      chk("to_err_vec", 64'(bus.rsp_err_vec), 64'd0);
      chk("to_cfg_err", 64'(bus.rsp_cfg_err), 64'd0);
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      chk("to_dropped", 64'(bus.rsp_valid), 64'd0);
      m_ptr = (w + 1) % NREQ;
      core_hang = 1'b0;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
